// File: rtl/cache_flush_seq_if.sv
// cache_flush_seq_if: tag/data array and main-memory ports of the flush sequencer
interface cache_flush_seq_if #(
  parameter int INDEX_BITS = 13,
  parameter int TAG_BITS   = 14
);
  logic                    st_rd;
  logic [INDEX_BITS-1:0]   st_idx;
  logic [3:0]              valid_in;
  logic [3:0]              dirty_in;
  logic [4*TAG_BITS-1:0]   tag_in;
  logic                    dary_rd;
  logic [1:0]              dary_way;
  logic [255:0]            dary_in;
  logic                    mm_req;
  logic [31:0]             mm_addr;
  logic [255:0]            mm_wd;
  logic                    mm_ack;
  logic                    clr;
  modport master (
    output st_rd, st_idx, dary_rd, dary_way, mm_req, mm_addr, mm_wd, clr,
    input  valid_in, dirty_in, tag_in, dary_in, mm_ack
  );
  modport slave (
    input  st_rd, st_idx, dary_rd, dary_way, mm_req, mm_addr, mm_wd, clr,
    output valid_in, dirty_in, tag_in, dary_in, mm_ack
  );
endinterface

// File: rtl/cache_flush_seq.sv
// cache_flush_seq: walks every set, writes back valid+dirty lines, then clears valid/dirty/LRU
module cache_flush_seq #(
  parameter int INDEX_BITS = 13,
  parameter int TAG_BITS   = 14
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  start_i,
  input  logic                  mode_i,
  input  logic                  cache_idle_i,
  output logic                  busy_o,
  output logic                  done_o,
  output logic [INDEX_BITS+2:0] wb_count_o,
  cache_flush_seq_if.master     bus
);
  typedef enum logic [3:0] {IDLE, RD_ST, CAP_ST, SCAN, RD_LN, CAP_LN, WB, CLR, DONE} state_e;
  state_e                state_q;
  logic                  mode_q;
  logic [3:0]            pend_q;
  logic [4*TAG_BITS-1:0] tag_q;
  logic                  busy_q, done_q, st_rd_q, dary_rd_q, mm_req_q, clr_q;
  logic [INDEX_BITS-1:0] idx_q;
  logic [1:0]            way_q, low_w;
  logic [31:0]           addr_q;
  logic [255:0]          wd_q;
  logic [INDEX_BITS+2:0] wb_q;
  always_comb low_w = pend_q[0] ? 2'd0 : pend_q[1] ? 2'd1 : pend_q[2] ? 2'd2 : 2'd3;
  assign busy_o       = busy_q;
  assign done_o       = done_q;
  assign wb_count_o   = wb_q;
  assign bus.st_rd    = st_rd_q;
  assign bus.st_idx   = idx_q;
  assign bus.dary_rd  = dary_rd_q;
  assign bus.dary_way = way_q;
  assign bus.mm_req   = mm_req_q;
  assign bus.mm_addr  = addr_q;
  assign bus.mm_wd    = wd_q;
  assign bus.clr      = clr_q;
  // outputs are set on entry to the state that owns them so each strobe lines up with its state
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      state_q   <= IDLE;
      mode_q    <= 1'b0;
      pend_q    <= '0;
      tag_q     <= '0;
      busy_q    <= 1'b0;
      done_q    <= 1'b0;
      st_rd_q   <= 1'b0;
      dary_rd_q <= 1'b0;
      mm_req_q  <= 1'b0;
      clr_q     <= 1'b0;
      idx_q     <= '0;
      way_q     <= '0;
      addr_q    <= '0;
      wd_q      <= '0;
      wb_q      <= '0;
    end else begin
      case (state_q)
        IDLE: if (start_i && cache_idle_i) begin
          idx_q   <= '0;
          wb_q    <= '0;
          mode_q  <= mode_i;
          busy_q  <= 1'b1;
          st_rd_q <= 1'b1;
          state_q <= RD_ST;
        end
        RD_ST: begin
          st_rd_q <= 1'b0;
          state_q <= CAP_ST;
        end
        CAP_ST: begin
          pend_q  <= mode_q ? bus.valid_in & bus.dirty_in : 4'b0;
          tag_q   <= bus.tag_in;
          state_q <= SCAN;
        end
        SCAN: if (~|pend_q) begin
          clr_q   <= 1'b1;
          state_q <= CLR;
        end else begin
          dary_rd_q <= 1'b1;
          way_q     <= low_w;
          state_q   <= RD_LN;
        end
        RD_LN: begin
          dary_rd_q <= 1'b0;
          state_q   <= CAP_LN;
        end
        CAP_LN: begin
          wd_q     <= bus.dary_in;
          addr_q   <= {tag_q[way_q*TAG_BITS +: TAG_BITS], idx_q, 5'b0};
          mm_req_q <= 1'b1;
          state_q  <= WB;
        end
        WB: if (bus.mm_ack) begin
          mm_req_q      <= 1'b0;
          pend_q[way_q] <= 1'b0;
          wb_q          <= wb_q + (INDEX_BITS+3)'(1);
          state_q       <= SCAN;
        end
        CLR: begin
          clr_q <= 1'b0;
          if (idx_q == '1) begin
            done_q  <= 1'b1;
            state_q <= DONE;
          end else begin
            idx_q   <= idx_q + (INDEX_BITS)'(1);
            st_rd_q <= 1'b1;
            state_q <= RD_ST;
          end
        end
        DONE: begin
          done_q  <= 1'b0;
          busy_q  <= 1'b0;
          state_q <= IDLE;
        end
        default: state_q <= IDLE;
      endcase
    end
endmodule
